// File: rtl/alien_fleet_pkg.sv
// Shared definitions for the alien fleet: FSM encoding and formation geometry.
package alien_fleet_pkg;
  typedef enum logic [2:0] {
    MARCH_RIGHT,
    MARCH_LEFT,
    DESCEND,
    LANDED,
    CLEARED
  } fleet_state_e;

  localparam int FLEET_ROWS  = 4;
  localparam int FLEET_COLS  = 8;
  localparam int COL_PITCH   = 2;
  localparam int FLEET_X_MAX = 17;
  localparam int NUM_ALIENS  = FLEET_ROWS * FLEET_COLS;
endpackage

// File: rtl/alien_hit_decode.sv
// Combinational bullet-vs-formation decode: which alien cell (if any live one) the bullet sits on.
module alien_hit_decode
  import alien_fleet_pkg::*;
(
  input  logic [4:0]            bullet_x_i,
  input  logic [3:0]            bullet_y_i,
  input  logic [4:0]            fleet_x_i,
  input  logic [3:0]            fleet_y_i,
  input  logic [NUM_ALIENS-1:0] alive_mask_i,
  output logic                  match_o,
  output logic [4:0]            idx_o
);
  logic [4:0] dx;
  logic [3:0] dy;
  logic       in_x, in_y;

  always_comb begin
    dx    = bullet_x_i - fleet_x_i;
    dy    = bullet_y_i - fleet_y_i;
    // Aliens sit on even column offsets only; odd offsets are the gaps between them.
    in_x  = (bullet_x_i >= fleet_x_i) && (dx <= 5'((FLEET_COLS - 1) * COL_PITCH)) && !dx[0];
    in_y  = (bullet_y_i >= fleet_y_i) && (dy < 4'(FLEET_ROWS));
    idx_o = {dy[1:0], dx[3:1]};
    match_o = in_x && in_y && alive_mask_i[idx_o];
  end
endmodule

// File: rtl/alien_fleet.sv
// Alien formation: tick-paced marching/descent FSM, bullet collision with one-kill-per-bullet, landing/clear detection.
module alien_fleet
  import alien_fleet_pkg::*;
#(
  parameter int STEP_DIV    = 8,
  parameter int LANDING_ROW = 14
) (
  input  logic        clk_36MHz,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        bullet_flying,
  input  logic [4:0]  bullet_x,
  input  logic [3:0]  bullet_y,
  output logic        hit,
  output logic [31:0] alive_mask,
  output logic [4:0]  fleet_x,
  output logic [3:0]  fleet_y,
  output logic        landed,
  output logic        wave_cleared
);
  fleet_state_e          state_q, state_d;
  logic [4:0]            fx_q, fx_d;
  logic [3:0]            fy_q, fy_d;
  logic [7:0]            tick_q, tick_d;
  logic [NUM_ALIENS-1:0] alive_q, alive_d;
  logic                  hit_q, hit_d;
  logic                  supp_q, supp_d;
  logic                  next_left_q, next_left_d;

  logic       match, active, coll, step;
  logic [4:0] idx;

  alien_hit_decode u_dec (
    .bullet_x_i   (bullet_x),
    .bullet_y_i   (bullet_y),
    .fleet_x_i    (fx_q),
    .fleet_y_i    (fy_q),
    .alive_mask_i (alive_q),
    .match_o      (match),
    .idx_o        (idx)
  );

  always_comb begin
    state_d     = state_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    tick_d      = tick_q;
    alive_d     = alive_q;
    hit_d       = 1'b0;
    supp_d      = supp_q;
    next_left_d = next_left_q;
    step        = 1'b0;
    active      = (state_q == MARCH_RIGHT) || (state_q == MARCH_LEFT) || (state_q == DESCEND);
    coll        = active && bullet_flying && !supp_q && match;

    if (clear) begin
      state_d     = MARCH_RIGHT;
      fx_d        = '0;
      fy_d        = '0;
      tick_d      = '0;
      alive_d     = '1;
      supp_d      = 1'b0;
      next_left_d = 1'b0;
    end else if (active) begin
      if (coll) begin
        hit_d        = 1'b1;
        alive_d[idx] = 1'b0;
        supp_d       = 1'b1;
      end else if (!bullet_flying) begin
        supp_d = 1'b0;
      end

      if (enable) begin
        if (tick_q == 8'(STEP_DIV - 1)) begin
          tick_d = '0;
          step   = 1'b1;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end

      // Collision above used the pre-step position; the step still applies this cycle.
      if (step) begin
        case (state_q)
          MARCH_RIGHT:
            if (fx_q == 5'(FLEET_X_MAX)) begin
              state_d     = DESCEND;
              next_left_d = 1'b1;
            end else begin
              fx_d = fx_q + 5'd1;
            end
          MARCH_LEFT:
            if (fx_q == 5'd0) begin
              state_d     = DESCEND;
              next_left_d = 1'b0;
            end else begin
              fx_d = fx_q - 5'd1;
            end
          DESCEND: begin
            fy_d = fy_q + 4'd1;
            if (int'(fy_q) + FLEET_ROWS >= LANDING_ROW) state_d = LANDED;
            else state_d = next_left_q ? MARCH_LEFT : MARCH_RIGHT;
          end
          default: ;
        endcase
      end

      // Landing outranks a wave clear seen in the same cycle.
      if (state_d != LANDED && alive_q == '0) state_d = CLEARED;
    end
  end

  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      state_q     <= MARCH_RIGHT;
      fx_q        <= '0;
      fy_q        <= '0;
      tick_q      <= '0;
      alive_q     <= '1;
      hit_q       <= 1'b0;
      supp_q      <= 1'b0;
      next_left_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      tick_q      <= tick_d;
      alive_q     <= alive_d;
      hit_q       <= hit_d;
      supp_q      <= supp_d;
      next_left_q <= next_left_d;
    end
  end

  assign hit          = hit_q;
  assign alive_mask   = alive_q;
  assign fleet_x      = fx_q;
  assign fleet_y      = fy_q;
  assign landed       = (state_q == LANDED);
  assign wave_cleared = (state_q == CLEARED);
endmodule

// File: tb/tb_alien_fleet.sv
// Directed bench for alien_fleet: one fast-stepping instance for behaviour, one default-divider instance for pacing.
module tb_alien_fleet;
  logic        clk = 1'b0;
  logic        reset, enable, clear, bullet_flying;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic        hit, landed, wave_cleared;
  logic [31:0] alive_mask;
  logic [4:0]  fleet_x;
  logic [3:0]  fleet_y;
  logic        s_hit, s_landed, s_wave;
  logic [31:0] s_mask;
  logic [4:0]  s_fx;
  logic [3:0]  s_fy;

  int checks = 0;
  int errors = 0;
  int nhits;

  always #5 clk = ~clk;

  alien_fleet #(.STEP_DIV(1), .LANDING_ROW(14)) dut (
    .clk_36MHz(clk), .reset(reset), .enable(enable), .clear(clear),
    .bullet_flying(bullet_flying), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hit(hit), .alive_mask(alive_mask), .fleet_x(fleet_x), .fleet_y(fleet_y),
    .landed(landed), .wave_cleared(wave_cleared)
  );

  alien_fleet u_slow (
    .clk_36MHz(clk), .reset(reset), .enable(enable), .clear(clear),
    .bullet_flying(bullet_flying), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hit(s_hit), .alive_mask(s_mask), .fleet_x(s_fx), .fleet_y(s_fy),
    .landed(s_landed), .wave_cleared(s_wave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
  endtask

  task automatic shoot(input logic [4:0] x, input logic [3:0] y);
    bullet_x = x;
    bullet_y = y;
    bullet_flying = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; bullet_flying = 1'b0;
    bullet_x = '0; bullet_y = '0;
    tick(); tick();
    chk("rst_mask", alive_mask, 32'hFFFF_FFFF);
    chk("rst_fx", 32'(fleet_x), 0);
    chk("rst_fy", 32'(fleet_y), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_landed", 32'(landed), 0);
    chk("rst_wave", 32'(wave_cleared), 0);
    reset = 1'b0;
    tick();

    // Single hit, one-cycle pulse, then suppression until the bullet drops.
    shoot(5'd4, 4'd2);
    tick();
    chk("hit_18", 32'(hit), 1);
    chk("mask_18", alive_mask, 32'hFFFB_FFFF);
    shoot(5'd6, 4'd2);
    tick();
    chk("hit_pulse_end", 32'(hit), 0);
    tick();
    chk("suppressed", 32'(hit), 0);
    chk("mask_suppressed", alive_mask, 32'hFFFB_FFFF);
    bullet_flying = 1'b0;
    tick();
    shoot(5'd6, 4'd2);
    tick();
    chk("hit_19", 32'(hit), 1);
    chk("mask_19", alive_mask, 32'hFFF3_FFFF);
    bullet_flying = 1'b0;
    tick();

    // Misses: odd offset, row below the formation, past the last column.
    shoot(5'd5, 4'd2);
    tick(); tick();
    chk("odd_miss", 32'(hit), 0);
    shoot(5'd4, 4'd4);
    tick(); tick();
    chk("row4_miss", 32'(hit), 0);
    shoot(5'd16, 4'd0);
    tick(); tick();
    chk("col16_miss", 32'(hit), 0);
    chk("mask_misses", alive_mask, 32'hFFF3_FFFF);
    shoot(5'd14, 4'd3);
    tick();
    chk("hit_31", 32'(hit), 1);
    chk("mask_31", alive_mask, 32'h7FF3_FFFF);
    bullet_flying = 1'b0;
    tick();

    // Clear beats collision and step in the same cycle.
    shoot(5'd0, 4'd0);
    clear = 1'b1; enable = 1'b1;
    tick();
    chk("clr_hit", 32'(hit), 0);
    chk("clr_mask", alive_mask, 32'hFFFF_FFFF);
    chk("clr_fx", 32'(fleet_x), 0);
    clear = 1'b0; enable = 1'b0;
    tick();
    chk("post_clr_hit", 32'(hit), 1);
    chk("post_clr_mask", alive_mask, 32'hFFFF_FFFE);
    bullet_flying = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Marching to the right edge and the first descent.
    for (int p = 1; p <= 20; p++) begin
      pulse();
      if (p == 7)  chk("slow_x_p7", 32'(s_fx), 0);
      if (p == 8)  chk("slow_x_p8", 32'(s_fx), 1);
      if (p == 17) begin chk("x_p17", 32'(fleet_x), 17); chk("y_p17", 32'(fleet_y), 0); end
      if (p == 18) begin chk("x_p18", 32'(fleet_x), 17); chk("y_p18", 32'(fleet_y), 0); end
      if (p == 19) begin chk("x_p19", 32'(fleet_x), 17); chk("y_p19", 32'(fleet_y), 1); end
      if (p == 20) begin chk("x_p20", 32'(fleet_x), 16); chk("slow_x_p20", 32'(s_fx), 2); end
    end

    // Collision resolves against the pre-step position.
    shoot(5'd16, 4'd1);
    enable = 1'b1;
    tick();
    chk("step_hit", 32'(hit), 1);
    chk("step_fx", 32'(fleet_x), 15);
    chk("step_mask", alive_mask, 32'hFFFF_FFFE);
    bullet_flying = 1'b0; enable = 1'b0;
    tick();

    // March down to the landing row.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int p = 1; p <= 208; p++) pulse();
    chk("pre_land_y", 32'(fleet_y), 10);
    chk("pre_land_x", 32'(fleet_x), 17);
    chk("pre_land", 32'(landed), 0);
    pulse();
    chk("land_y", 32'(fleet_y), 11);
    chk("landed", 32'(landed), 1);
    shoot(5'd17, 4'd11);
    for (int p = 0; p < 3; p++) begin
      enable = 1'b1;
      tick();
      chk("landed_no_hit", 32'(hit), 0);
      enable = 1'b0;
      tick();
    end
    chk("frozen_x", 32'(fleet_x), 17);
    chk("frozen_y", 32'(fleet_y), 11);
    chk("frozen_mask", alive_mask, 32'hFFFF_FFFF);
    bullet_flying = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("unland_x", 32'(fleet_x), 0);
    chk("unland_y", 32'(fleet_y), 0);
    chk("unland_mask", alive_mask, 32'hFFFF_FFFF);
    chk("unland", 32'(landed), 0);

    // Destroy the whole wave.
    nhits = 0;
    for (int i = 0; i < 32; i++) begin
      shoot(5'((i % 8) * 2), 4'(i / 8));
      tick();
      nhits += int'(hit);
      if (i == 31) chk("wave_lag", 32'(wave_cleared), 0);
      bullet_flying = 1'b0;
      tick();
    end
    chk("all_hits", 32'(nhits), 32);
    chk("empty_mask", alive_mask, 32'h0);
    chk("wave_cleared", 32'(wave_cleared), 1);
    pulse(); pulse();
    chk("cleared_frozen", 32'(fleet_x), 0);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    chk("async_wave", 32'(wave_cleared), 0);
    chk("async_mask", alive_mask, 32'hFFFF_FFFF);
    #1 reset = 1'b0;
    tick();
    pulse(); pulse();
    chk("remarch_x", 32'(fleet_x), 2);
    shoot(5'd2, 4'd0);
    tick();
    chk("pend_hit", 32'(hit), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_hit", 32'(hit), 0);
    chk("async_fx", 32'(fleet_x), 0);
    chk("async_mask2", alive_mask, 32'hFFFF_FFFF);
    bullet_flying = 1'b0;
    #1 reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alien_fleet.md
ALIEN_FLEET -- requirements
Module: alien_fleet

Interface
REQ-001 Parameter STEP_DIV, default 8, number of enable ticks per fleet step (legal 1..255).
REQ-002 Parameter LANDING_ROW, default 14, playfield row at which the fleet's bottom row counts as landed.
REQ-003 clk_36MHz  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  game-tick strobe, one cycle wide; paces marching only.
REQ-006 clear  in  1  synchronous restart of the wave.
REQ-007 bullet_flying  in  1  player bullet is in flight.
REQ-008 bullet_x  in  5  bullet column, 0..31.
REQ-009 bullet_y  in  4  bullet row, 0..15.
REQ-010 hit  out  1  one-cycle pulse: the bullet struck a live alien; drives the player's hit input.
REQ-011 alive_mask  out  32  bit r*8+c = alien at row r (0..3), column c (0..7) alive.
REQ-012 fleet_x  out  5  column of alien column 0.
REQ-013 fleet_y  out  4  row of alien row 0.
REQ-014 landed  out  1  level; fleet reached LANDING_ROW.
REQ-015 wave_cleared  out  1  level; all 32 aliens destroyed.

Function
REQ-016 Geometry: alien (r,c) occupies cell (fleet_x+2c, fleet_y+r); fleet_x legal range 0..17, fleet_y 0..15.
REQ-017 FSM states MARCH_RIGHT, MARCH_LEFT, DESCEND, LANDED, CLEARED; state after reset or clear is MARCH_RIGHT.
REQ-018 A step occurs on the cycle the tick counter, incremented by each enable pulse, reaches STEP_DIV; the counter then returns to 0.
REQ-019 MARCH_RIGHT step: fleet_x+1 if fleet_x<17; if fleet_x==17, go to DESCEND without moving.
REQ-020 MARCH_LEFT step: fleet_x-1 if fleet_x>0; if fleet_x==0, go to DESCEND without moving.
REQ-021 DESCEND step: fleet_y+1, then enter the march direction opposite to the previous one; if new fleet_y+3 >= LANDING_ROW, enter LANDED instead.
REQ-022 LANDED and CLEARED freeze position, tick counter and alive_mask until reset or clear; hit stays 0.
REQ-023 Collision, evaluated every cycle with bullet_flying=1 and state in MARCH_RIGHT/MARCH_LEFT/DESCEND: r=bullet_y-fleet_y in 0..3, d=bullet_x-fleet_x in 0..14 and even, c=d/2, alive_mask[r*8+c]=1.
REQ-024 On collision, the following cycle hit=1 for exactly one cycle and the alien bit is cleared on that same edge (1-cycle latency).
REQ-025 After a hit, collisions are suppressed until bullet_flying has been sampled 0 at least once (one kill per bullet).
REQ-026 Collision uses the position before any step occurring in the same cycle; the step still applies.
REQ-027 When alive_mask becomes 0, enter CLEARED on the next cycle; wave_cleared=1 while in CLEARED.
REQ-028 landed=1 exactly while in LANDED; LANDED has priority if the landing step and the final kill occur in the same cycle.
REQ-029 clear has priority over enable, collision and step in the same cycle.

Reset
REQ-030 Reset or clear: alive_mask=32'hFFFF_FFFF, fleet_x=0, fleet_y=0, tick counter 0, hit=0, landed=0, wave_cleared=0, suppression cleared.
REQ-031 Reset asserted mid-operation takes effect immediately, independent of the clock; a pending hit pulse is discarded.

Structure
REQ-032 Shared package holds the FSM state encoding, FLEET_ROWS=4, FLEET_COLS=8, COL_PITCH=2, FLEET_X_MAX=17.
REQ-033 Collision decode is a sub-module alien_hit_decode (combinational: bullet and fleet position, alive_mask in; match and bit index out); everything else is in alien_fleet.

Verification
REQ-034 Reset, STEP_DIV=1, 17 enable pulses -> fleet_x=17, state MARCH_RIGHT; 18th -> DESCEND, fleet_x=17; 19th -> fleet_y=1, MARCH_LEFT.
REQ-035 fleet at (0,0), bullet_flying=1, bullet (4,2) -> next cycle hit=1 for one cycle, alive_mask bit 18 cleared; bullet held there -> no further hit until bullet_flying toggles 0.
REQ-036 Bullet at odd offset (5,2) or row 4 with fleet at (0,0) -> hit never asserts, alive_mask unchanged.
REQ-037 Kill all 32 aliens sequentially -> wave_cleared=1 one cycle after the last hit; further enable pulses do not move the fleet.
REQ-038 LANDING_ROW=14, march until fleet_y=11 -> landed=1, position frozen; assert clear -> fleet (0,0), alive_mask all ones, landed=0.
REQ-039 Collision, step and clear in one cycle -> clear wins, no hit; reset asserted between clock edges -> outputs at reset values before the next edge.
